// File: rtl/data_mem_ctrl_pkg.sv
// Shared opcodes, bus size codes and FSM state encoding for the MEM-stage data memory controller.
// Opcode values mirror the load/store entries of defines2.vh.
package data_mem_ctrl_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// SRAM-like data bus between the MEM-stage controller (master) and memory (slave).
// Handshake: request fields are held stable while data_req=1 and complete on the cycle data_addr_ok=1;
// each accepted request is answered by exactly one data_data_ok cycle carrying data_rdata (loads) or the write ack.
interface data_mem_ctrl_if #(parameter int ADDR_W = 32);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_wstrb;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_mem_ctrl_lane_gen.sv
// Combinational decode of a load/store: bus size, byte enables, lane-replicated store data
// and the alignment errors for loads and stores.
module mem_lane_gen
  import data_mem_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addrLo,
  input  logic [31:0] wdata,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] laneWdata,
  output logic        wr,
  output logic        adel,
  output logic        ades
);

  always_comb begin
    size      = SIZE_WORD;
    wstrb     = 4'b0000;
    laneWdata = wdata;
    wr        = 1'b0;
    adel      = 1'b0;
    ades      = 1'b0;
    case (op)
      OP_LB, OP_LBU: size = SIZE_BYTE;
      OP_LH, OP_LHU: begin
        size = SIZE_HALF;
        adel = addrLo[0];
      end
      OP_LW: adel = |addrLo;
      OP_SB: begin
        size      = SIZE_BYTE;
        wr        = 1'b1;
        wstrb     = 4'b0001 << addrLo;
        laneWdata = {4{wdata[7:0]}};
      end
      OP_SH: begin
        size      = SIZE_HALF;
        wr        = 1'b1;
        wstrb     = addrLo[1] ? 4'b1100 : 4'b0011;
        laneWdata = {2{wdata[15:0]}};
        ades      = addrLo[0];
      end
      OP_SW: begin
        wr    = 1'b1;
        wstrb = 4'b1111;
        ades  = |addrLo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: one outstanding bus transaction, pipeline stall until
// data returns, and silent draining of responses that belong to a flushed instruction.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_en,
  input  logic [5:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              flush,
  input  logic              pipe_hold,
  output logic              stall_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [31:0]       rdata_o,
  output state_t            dbgState,
  data_mem_ctrl_if.master   bus
);

  state_t            state, stateNext;
  logic [1:0]        laneSize;
  logic [3:0]        laneWstrb;
  logic [31:0]       laneWdata;
  logic              laneWr, laneAdel, laneAdes;
  logic              start;
  logic              reqWr;
  logic [1:0]        reqSize;
  logic [ADDR_W-1:0] reqAddr;
  logic [3:0]        reqWstrb;
  logic [31:0]       reqWdata;
  logic [31:0]       rdataQ;
  logic              pendingAtReset;

  mem_lane_gen u_lane (
    .op        (op),
    .addrLo    (addr[1:0]),
    .wdata     (wdata),
    .size      (laneSize),
    .wstrb     (laneWstrb),
    .laneWdata (laneWdata),
    .wr        (laneWr),
    .adel      (laneAdel),
    .ades      (laneAdes)
  );

  assign adel_o = mem_en & laneAdel;
  assign ades_o = mem_en & laneAdes;
  assign start  = mem_en & ~flush & ~laneAdel & ~laneAdes;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      reqWr    <= 1'b0;
      reqSize  <= 2'd0;
      reqAddr  <= '0;
      reqWstrb <= 4'b0000;
      reqWdata <= 32'd0;
      rdataQ   <= 32'd0;
      // Remember that a bus response may still arrive for a transaction cut off by reset.
      pendingAtReset <= pendingAtReset | (state != ST_IDLE && state != ST_DONE);
    end else begin
      state <= stateNext;
      if (state == ST_IDLE && start) begin
        reqWr    <= laneWr;
        reqSize  <= laneSize;
        reqAddr  <= addr;
        reqWstrb <= laneWstrb;
        reqWdata <= laneWdata;
      end
      if (state == ST_WAIT && bus.data_data_ok && !flush && !reqWr)
        rdataQ <= bus.data_rdata;
      if (bus.data_data_ok || state != ST_IDLE)
        pendingAtReset <= 1'b0;
      assert (!(bus.data_data_ok &&
                (state == ST_REQ || (state == ST_IDLE && !pendingAtReset))))
        else $error("data_ok with no transaction outstanding");
    end
  end

  always_comb begin
    stateNext = state;
    stall_o   = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        stall_o   = 1'b1;
        stateNext = ST_REQ;
      end
      ST_REQ: begin
        stall_o = 1'b1;
        // Once addr_ok is seen the bus owes us a data_ok, so a flush must drain it.
        if (flush)                  stateNext = bus.data_addr_ok ? ST_DRAIN : ST_IDLE;
        else if (bus.data_addr_ok)  stateNext = ST_WAIT;
      end
      ST_WAIT: begin
        stall_o = 1'b1;
        if (flush)                  stateNext = bus.data_data_ok ? ST_IDLE : ST_DRAIN;
        else if (bus.data_data_ok)  stateNext = ST_DONE;
      end
      ST_DONE: if (!pipe_hold || flush) stateNext = ST_IDLE;
      ST_DRAIN: begin
        stall_o = mem_en & ~flush;
        if (bus.data_data_ok) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign bus.data_req   = (state == ST_REQ);
  assign bus.data_wr    = reqWr;
  assign bus.data_size  = reqSize;
  assign bus.data_addr  = reqAddr;
  assign bus.data_wstrb = reqWstrb;
  assign bus.data_wdata = reqWdata;
  assign rdata_o        = rdataQ;
  assign dbgState       = state;

endmodule
